// File: rtl/calc_arbiter.sv
// -----------------------------------------------------------------------------
// calc_arbiter
//
// Round-robin front end that lets two clients share one Calculator datapath.
// A client raises its req bit with a stable 18-bit command {op, a, b}. The
// arbiter picks a winner, drives the command onto calc_din, waits CALC_LAT
// cycles for the calculator pipeline, captures RESULT/NEG and returns them
// with a one-cycle ack. The reserved op 2'b11 is answered at once with rsp_err
// set and never reaches the calculator.
//
// Parameters
//   CALC_LAT     cycles from a new calc_din value to valid calc_result (1..15)
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   req[1:0]     request level per client
//   req0_din     client 0 command {op[1:0], a[7:0], b[7:0]}
//   req1_din     client 1 command, same format
//   ack[1:0]     one-cycle acknowledge to the served client
//   rsp_result   result returned to the client (held after ack)
//   rsp_neg      sign flag returned to the client
//   rsp_err      reserved-op flag returned to the client
//   busy         high whenever the arbiter is not idle
//   grant        index of the client currently or last served
//   calc_din     registered command bus to Calculator.DIN
//   calc_result  Calculator.RESULT
//   calc_neg     Calculator.NEG
// -----------------------------------------------------------------------------
module calc_arbiter #(
    parameter int CALC_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [17:0] req0_din,
    input  logic [17:0] req1_din,
    output logic [1:0]  ack,
    output logic [15:0] rsp_result,
    output logic        rsp_neg,
    output logic        rsp_err,
    output logic        busy,
    output logic        grant,
    output logic [17:0] calc_din,
    input  logic [15:0] calc_result,
    input  logic        calc_neg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(CALC_LAT - 1);
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        grant_reg, grant_next;
    logic        rr_last_reg, rr_last_next;
    logic [17:0] calc_din_reg, calc_din_next;
    logic [15:0] result_reg, result_next;
    logic        neg_reg, neg_next;
    logic        err_reg, err_next;
    logic [1:0]  ack_reg, ack_next;

    logic        winner;
    logic [17:0] win_din;

    // Single requester wins outright; on a tie the client not served last wins.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~rr_last_reg;
            default: winner = 1'b0;
        endcase
    end

    assign win_din = winner ? req1_din : req0_din;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        grant_next    = grant_reg;
        rr_last_next  = rr_last_reg;
        calc_din_next = calc_din_reg;
        result_next   = result_reg;
        neg_next      = neg_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    grant_next = winner;
                    if (win_din[17:16] == OP_RSVD) begin
                        // Reserved op is answered directly; calc_din keeps its
                        // last issued command.
                        err_next    = 1'b1;
                        result_next = 16'd0;
                        neg_next    = 1'b0;
                        state_next  = RESP;
                    end else begin
                        calc_din_next = win_din;
                        cnt_next      = LAT_M1;
                        state_next    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    result_next = calc_result;
                    neg_next    = calc_neg;
                    err_next    = 1'b0;
                    state_next  = RESP;
                end
            end
            RESP: begin
                rr_last_next = grant_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ack is registered from the next-state decode so it comes straight off a
    // flop; it is high exactly in the RESP cycle for the granted client.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_next[gi] = (state_next == RESP) && (grant_next == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            grant_reg    <= 1'b0;
            rr_last_reg  <= 1'b1;
            calc_din_reg <= 18'd0;
            result_reg   <= 16'd0;
            neg_reg      <= 1'b0;
            err_reg      <= 1'b0;
            ack_reg      <= 2'b00;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            grant_reg    <= grant_next;
            rr_last_reg  <= rr_last_next;
            calc_din_reg <= calc_din_next;
            result_reg   <= result_next;
            neg_reg      <= neg_next;
            err_reg      <= err_next;
            ack_reg      <= ack_next;
        end
    end

    assign ack        = ack_reg;
    assign rsp_result = result_reg;
    assign rsp_neg    = neg_reg;
    assign rsp_err    = err_reg;
    assign busy       = (state_reg != IDLE);
    assign grant      = grant_reg;
    assign calc_din   = calc_din_reg;

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Two-requester front end for the shared `Calculator` datapath. It accepts 18-bit command words from two clients through a req/ack handshake and grants the calculator to one client at a time, using round-robin priority. It drives the calculator's `DIN` bus, waits a fixed pipeline latency, captures `RESULT`/`NEG`, and returns them to the granted client with a one-cycle acknowledge. The block sits between the client logic and the `Calculator` instance; the calculator itself is unchanged.

## Interface
- `CALC_LAT`, default 2: number of cycles from a new `calc_din` value to a valid `calc_result`/`calc_neg`. Legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `req` input 2: request level per client; bit i belongs to client i.
- `req0_din` input 18: client 0 command `{op[1:0], a[7:0], b[7:0]}`. Must be stable while `req[0]`=1.
- `req1_din` input 18: client 1 command, same format.
- `ack` output 2: one-cycle pulse to the served client.
- `rsp_result` output 16: result returned to the client. Valid only in the `ack` cycle; held afterwards.
- `rsp_neg` output 1: sign flag returned to the client. Valid in the `ack` cycle.
- `rsp_err` output 1: set to 1 in the `ack` cycle when op=2'b11 (reserved).
- `busy` output 1: high in every state except IDLE.
- `grant` output 1: index of the client currently or last served.
- `calc_din` output 18: registered command bus to `Calculator.DIN`.
- `calc_result` input 16: from `Calculator.RESULT`.
- `calc_neg` input 1: from `Calculator.NEG`.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If no `req` bit is set, remain in IDLE.
  - If exactly one bit is set, that client wins.
  - If both bits are set, the winner is `~rr_last`.
  - On the edge: `grant`←winner. `rr_last` is updated in RESP, not here.
  - If the winner's op is 00, 01 or 10: `calc_din`←winner's din, `cnt`←`CALC_LAT`-1, go to WAIT.
  - If the winner's op is 11: do not touch `calc_din`; set `rsp_err`←1, `rsp_result`←0, `rsp_neg`←0, go to RESP.
- **WAIT**
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: `rsp_result`←`calc_result`, `rsp_neg`←`calc_neg`, `rsp_err`←0, go to RESP.
- **RESP**
  - `ack[grant]`=1 for this cycle only.
  - On the edge: `rr_last`←`grant`, go to IDLE.
- `ack` is decoded from state and `grant` and is glitch-free. Both `ack` bits are never high together.
- Client rule: deassert `req` on the edge that ends the `ack` cycle. A `req` bit still high in the following IDLE cycle is a new request.
- While a request is pending, its din must not change. A client withdrawing `req` before `ack` is illegal. The arbiter completes the transaction anyway and pulses `ack` regardless.
- Requests arriving during WAIT or RESP are held off. No queueing beyond the `req` level is provided.
- The arbiter does no arithmetic. Results are passed through bit-exact from the calculator.

## Timing
- Reset values: state=IDLE, `calc_din`=0, `rsp_result`=0, `rsp_neg`=0, `rsp_err`=0, `ack`=0, `busy`=0, `grant`=0, `rr_last`=1, `cnt`=0.
  - With `rr_last`=1, client 0 wins the first tie.
- Latency for a legal op: `req` sampled in IDLE at cycle 0 → `calc_din` updated at the start of cycle 1 → WAIT occupies cycles 1..`CALC_LAT` → `ack` in cycle `CALC_LAT`+1.
- Latency for an illegal op: `ack` in cycle 1.
- Throughput: one transaction per `CALC_LAT`+2 cycles. This follows from IDLE (1 cycle) + WAIT + RESP.
- Back-to-back requests from the same client with the other client idle: that client is re-granted in the IDLE cycle after RESP.
- Reset asserted mid-WAIT or mid-RESP:
  - The transaction is lost and no `ack` is emitted.
  - `calc_din` returns to 0.
  - Clients must re-request after `reset` goes high.
- `calc_din` holds its last issued value across IDLE.

## Test plan
- **Single add:** `CALC_LAT`=2, stub calculator returns a+b after 2 cycles. `req`=01, `req0_din`=00_00010010_00000111. Expect:
  - `calc_din` updated in cycle 1.
  - `ack`=01 in cycle 3, with `rsp_result`=0x0019, `rsp_neg`=0, `rsp_err`=0.
- **Tie and round-robin:** both clients request persistently. Expect grants alternating 0,1,0,1 across four transactions, with `ack` pulses exactly 4 cycles apart.
- **Reserved op:** `req1_din`=11_00000000_00000000. Expect:
  - `ack`=10 one cycle after sampling, with `rsp_err`=1 and `rsp_result`=0.
  - `calc_din` unchanged.
- **Negative pass-through:** stub drives `calc_result`=0x0065, `calc_neg`=1 for op 01, a=0x36, b=0x9B. Expect `rsp_result`=0x0065, `rsp_neg`=1 in the `ack` cycle.
- **Reset mid-operation:** assert `reset`=0 during WAIT. Expect:
  - All outputs go to their reset values immediately.
  - No `ack` is emitted.
  - After release, a re-issued request completes normally, with client 0 winning the first tie.
- **Latency sweep:** `CALC_LAT`=1 and `CALC_LAT`=5. Expect `ack` at cycle 2 and cycle 6 respectively. A stub whose result is valid only at that exact cycle must be captured correctly.
